axis_output_packer: RTL and testbench

Receives the accelerator's wide, sparsely-kept output stream (`GROUPS*UNITS_EDGES*COPIES` words per beat, with per-word `tkeep`) and packs it into a dense, narrow AXI-Stream for the output DMA. It sits between the maxpool engine output of the accelerator top and the S2MM DMA. Only kept words are forwarded, with no gaps and in ascending word-index order. Packet boundaries (`tlast`) are preserved exactly.

---
 rtl/axis_output_packer_if.sv | 14 +
 rtl/axis_output_packer.sv | 99 +++++++++
 tb/tb_axis_output_packer.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/axis_output_packer_if.sv
// AXI-Stream bundle shared by the wide input side and the narrow output side of the packer.
interface axis_output_packer_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned KEEP_W = 4
);
    logic              tvalid;
    logic              tready;
    logic [DATA_W-1:0] tdata;
    logic [KEEP_W-1:0] tkeep;
    logic              tlast;

    modport master (output tvalid, output tdata, output tkeep, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tkeep, input tlast, output tready);
endinterface

// File: rtl/axis_output_packer.sv
// Packs a wide, sparsely-kept AXI-Stream into a dense narrow stream, preserving tlast.
module axis_output_packer #(
    parameter int unsigned WORD_WIDTH = 8,
    parameter int unsigned IN_WORDS   = 12,
    parameter int unsigned OUT_BITS   = 32
) (
    input  logic                 aclk,
    input  logic                 areset,
    axis_output_packer_if.slave  s_axis,
    axis_output_packer_if.master m_axis
);
    localparam int unsigned OUT_WORDS      = OUT_BITS / WORD_WIDTH;
    localparam int unsigned CAP            = IN_WORDS + OUT_WORDS - 1;
    localparam int unsigned BITS_COUNT     = $clog2(CAP + 1);
    localparam int unsigned IDX_W          = (CAP > 1) ? $clog2(CAP) : 1;
    localparam int unsigned BYTES_PER_WORD = WORD_WIDTH / 8;

    localparam logic [BITS_COUNT-1:0] OutWordsC = BITS_COUNT'(OUT_WORDS);
    localparam logic [BITS_COUNT-1:0] CapC      = BITS_COUNT'(CAP);
    localparam logic [BITS_COUNT-1:0] OneC      = BITS_COUNT'(1);

    logic [WORD_WIDTH-1:0] word_q [CAP];
    logic [WORD_WIDTH-1:0] word_d [CAP];
    logic [BITS_COUNT-1:0] count_q, count_d;
    logic                  last_q, last_d;

    logic                  in_hs;
    logic                  out_hs;
    logic [BITS_COUNT-1:0] take;
    logic [BITS_COUNT-1:0] pos;

    // Accept only when the buffer can absorb a full beat; never depends on m_axis.tready.
    assign s_axis.tready = !areset && (count_q < OutWordsC) && !last_q;
    assign in_hs         = s_axis.tvalid && s_axis.tready;
    assign out_hs        = m_axis.tvalid && m_axis.tready;
    assign take          = (count_q < OutWordsC) ? count_q : OutWordsC;

    // State registers: buffered words, fill level and pending end-of-packet.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            for (int i = 0; i < CAP; i++) begin
                word_q[i] <= '0;
            end
            count_q <= '0;
            last_q  <= 1'b0;
        end else begin
            for (int i = 0; i < CAP; i++) begin
                word_q[i] <= word_d[i];
            end
            count_q <= count_d;
            last_q  <= last_d;
        end
    end

    // Next state: compact kept words onto the tail on input, shift down one beat on output.
    always_comb begin
        word_d  = word_q;
        count_d = count_q;
        last_d  = last_q;
        pos     = count_q;
        if (in_hs) begin
            for (int i = 0; i < IN_WORDS; i++) begin
                if (s_axis.tkeep[i]) begin
                    if (pos < CapC) begin
                        word_d[pos[IDX_W-1:0]] = s_axis.tdata[i*WORD_WIDTH +: WORD_WIDTH];
                    end
                    pos = pos + OneC;
                end
            end
            count_d = pos;
            last_d  = last_q | s_axis.tlast;
        end else if (out_hs) begin
            for (int j = 0; j < CAP - OUT_WORDS; j++) begin
                word_d[IDX_W'(j)] = word_q[IDX_W'(j + OUT_WORDS)];
            end
            for (int j = CAP - OUT_WORDS; j < CAP; j++) begin
                word_d[IDX_W'(j)] = '0;
            end
            count_d = count_q - take;
            if (m_axis.tlast) begin
                last_d = 1'b0;
            end
        end
    end

    // Output beat: head of the buffer, keep covers only the valid words, null beat on empty last.
    always_comb begin
        m_axis.tdata = '0;
        m_axis.tkeep = '0;
        for (int j = 0; j < OUT_WORDS; j++) begin
            m_axis.tdata[j*WORD_WIDTH +: WORD_WIDTH] = word_q[IDX_W'(j)];
            if (BITS_COUNT'(j) < count_q) begin
                m_axis.tkeep[j*BYTES_PER_WORD +: BYTES_PER_WORD] = '1;
            end
        end
        m_axis.tvalid = (count_q >= OutWordsC) || last_q;
        m_axis.tlast  = last_q && (count_q <= OutWordsC);
    end
endmodule

// File: tb/tb_axis_output_packer.sv
// Scoreboard bench: stimulus pushes expected beats, a negedge monitor pops and compares.
module tb_axis_output_packer;
    logic aclk = 1'b0;
    logic areset;

    always #5 aclk = ~aclk;

    axis_output_packer_if #(.DATA_W(96), .KEEP_W(12)) s_if ();
    axis_output_packer_if #(.DATA_W(32), .KEEP_W(4))  m_if ();

    axis_output_packer #(
        .WORD_WIDTH(8),
        .IN_WORDS  (12),
        .OUT_BITS  (32)
    ) dut (
        .aclk  (aclk),
        .areset(areset),
        .s_axis(s_if.slave),
        .m_axis(m_if.master)
    );

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] mask;
        logic [3:0]  keep;
        logic        last;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int   n_cmp   = 0;
    int   n_err   = 0;
    int   beat_no = 0;

    localparam logic [95:0] FullData = 96'h0C0B0A09_08070605_04030201;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, req);
        end
    endtask

    task automatic push(input logic [31:0] data, input logic [31:0] mask, input logic [3:0] keep,
                        input logic last);
        exp_t e;
        e.data = data;
        e.mask = mask;
        e.keep = keep;
        e.last = last;
        exp_q.push_back(e);
    endtask

    task automatic push_full();
        push(32'h04030201, 32'hFFFF_FFFF, 4'hF, 1'b0);
        push(32'h08070605, 32'hFFFF_FFFF, 4'hF, 1'b0);
        push(32'h0C0B0A09, 32'hFFFF_FFFF, 4'hF, 1'b1);
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [95:0] data, input logic [11:0] keep, input logic last);
        bit hs = 1'b0;
        s_if.tvalid = 1'b1;
        s_if.tdata  = data;
        s_if.tkeep  = keep;
        s_if.tlast  = last;
        for (int c = 0; c < 50 && !hs; c++) begin
            @(negedge aclk);
            hs = s_if.tready;
            @(posedge aclk);
            #1;
        end
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tkeep  = '0;
        s_if.tlast  = 1'b0;
        if (!hs) begin
            n_cmp++;
            n_err++;
            $display("FAIL accept_timeout: got tready=0 for 50 cycles, want accept");
        end
    endtask

    task automatic drain(input string name);
        for (int c = 0; c < 100 && exp_q.size() > 0; c++) begin
            @(posedge aclk);
            #1;
        end
        chk(name, exp_q.size(), 0);
        repeat (3) @(posedge aclk);
        #1;
    endtask

    // Monitor: every output handshake must match the head of the expected queue.
    always @(negedge aclk) begin
        if (!areset && m_if.tvalid && m_if.tready) begin
            beat_no++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_beat%0d: got data 0x%08h keep 0x%0h last %0b, want none",
                         beat_no, m_if.tdata, m_if.tkeep, m_if.tlast);
            end else begin
                cur = exp_q.pop_front();
                chk($sformatf("beat%0d_data", beat_no), m_if.tdata & cur.mask,
                    cur.data & cur.mask);
                chk($sformatf("beat%0d_keep", beat_no), 32'(m_if.tkeep), 32'(cur.keep));
                chk($sformatf("beat%0d_last", beat_no), 32'(m_if.tlast), 32'(cur.last));
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got simulation still running, want finished");
        $fatal(1);
    end

    initial begin
        areset      = 1'b1;
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tkeep  = '0;
        s_if.tlast  = 1'b0;
        m_if.tready = 1'b1;
        repeat (3) @(posedge aclk);
        #1;
        chk("rst_mvalid", 32'(m_if.tvalid), 0);
        chk("rst_mdata", m_if.tdata, 0);
        chk("rst_mkeep", 32'(m_if.tkeep), 0);
        chk("rst_mlast", 32'(m_if.tlast), 0);
        chk("rst_sready", 32'(s_if.tready), 0);
        @(negedge aclk);
        areset = 1'b0;
        #1;
        chk("ready_after_reset", 32'(s_if.tready), 1);
        @(posedge aclk);
        #1;

        // Full beat, plus one-cycle latency to first output.
        push_full();
        send(FullData, 12'hFFF, 1'b1);
        chk("latency_valid", 32'(m_if.tvalid), 1);
        drain("full_drain");

        // Sparse keep: only words 4..7 survive.
        push(32'h08070605, 32'hFFFF_FFFF, 4'hF, 1'b1);
        send(FullData, 12'h0F0, 1'b1);
        drain("sparse_drain");

        // Residue carried across beats.
        push(32'h14131211, 32'hFFFF_FFFF, 4'hF, 1'b0);
        push(32'h22211615, 32'hFFFF_FFFF, 4'hF, 1'b0);
        push(32'h00000023, 32'h0000_00FF, 4'h1, 1'b1);
        send(96'h16_15_14_13_12_11, 12'h03F, 1'b0);
        repeat (4) @(posedge aclk);
        #1;
        chk("residue_held_valid", 32'(m_if.tvalid), 0);
        chk("residue_pending", exp_q.size(), 2);
        send(96'h23_22_21, 12'h007, 1'b1);
        drain("residue_drain");

        // Backpressure at the first output beat.
        m_if.tready = 1'b0;
        push_full();
        send(FullData, 12'hFFF, 1'b1);
        for (int k = 0; k < 10; k++) begin
            @(negedge aclk);
            chk("bp_data", m_if.tdata, 32'h04030201);
            chk("bp_valid", 32'(m_if.tvalid), 1);
            chk("bp_sready", 32'(s_if.tready), 0);
        end
        @(posedge aclk);
        #1;
        m_if.tready = 1'b1;
        drain("bp_drain");

        // Null last beat, then a normal packet must still be accepted.
        push(32'h0, 32'h0, 4'h0, 1'b1);
        send(96'h0, 12'h000, 1'b1);
        drain("null_drain");
        push_full();
        send(FullData, 12'hFFF, 1'b1);
        drain("after_null_drain");

        // Reset after the first output beat of a full packet.
        push_full();
        send(FullData, 12'hFFF, 1'b1);
        for (int c = 0; c < 20 && exp_q.size() != 2; c++) begin
            @(posedge aclk);
            #1;
        end
        chk("rst_mid_wait", exp_q.size(), 2);
        areset = 1'b1;
        #1;
        chk("rst_mid_mvalid", 32'(m_if.tvalid), 0);
        chk("rst_mid_mdata", m_if.tdata, 0);
        chk("rst_mid_sready", 32'(s_if.tready), 0);
        exp_q.delete();
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        areset = 1'b0;
        @(posedge aclk);
        #1;
        chk("rst_mid_idle", 32'(m_if.tvalid), 0);
        push_full();
        send(FullData, 12'hFFF, 1'b1);
        drain("post_reset_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
